// File: rtl/ldpc_cn_fu_pkg.sv
// ---------------------------------------------------------------------------
// ldpc_cn_fu_pkg
// Shared types and constants for the LDPC check-node functional unit.
//   - fu_op_t / fu_data_t : slice of the ex_stage issue bus used by this unit
//   - cn_state_t          : accumulator occupancy state encoding
//   - cn_acc_t            : check-node accumulator contents
//   - cn_pack_result()    : packs an accumulator (with optional offset) into
//                           the XLEN result word returned on LDN_CN_RD
// Optional feature macro used by the unit: LDPC_CN_OFFSET_EN
// ---------------------------------------------------------------------------
package ldpc_cn_fu_pkg;

    localparam int XLEN          = 64;
    localparam int TRANS_ID_BITS = 3;

    // LLR width, saturated magnitude width and row degree
    localparam int Q        = 8;
    localparam int CN_MAG_W = 6;
    localparam int DEG_MAX  = 32;
    localparam int CN_CNT_W = $clog2(DEG_MAX) + 1;

    localparam logic [CN_MAG_W-1:0] CN_MAG_MAX = 6'd63;

    typedef enum logic [3:0] {
        ADD,
        SUB,
        LDN_MIN,
        LDN_ADDUSAT,
        LDN_SUBUSAT,
        LDN_CN_CLR,
        LDN_CN_ACC,
        LDN_CN_RD
    } fu_op_t;

    typedef struct packed {
        fu_op_t                   operation;
        logic [XLEN-1:0]          operand_a;
        logic [XLEN-1:0]          operand_b;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } fu_data_t;

    // Occupancy FSM encoding
    typedef logic [1:0] cn_state_t;
    localparam cn_state_t CN_EMPTY = 2'd0;
    localparam cn_state_t CN_ACCUM = 2'd1;
    localparam cn_state_t CN_FULL  = 2'd2;

    typedef struct packed {
        logic [CN_MAG_W-1:0] min1;
        logic [CN_MAG_W-1:0] min2;
        logic [CN_CNT_W-1:0] idx;
        logic                sign;
        logic [CN_CNT_W-1:0] cnt;
        logic                ovf;
    } cn_acc_t;

    localparam cn_acc_t CN_ACC_RST = '{
        min1: CN_MAG_MAX,
        min2: CN_MAG_MAX,
        idx:  '0,
        sign: 1'b0,
        cnt:  '0,
        ovf:  1'b0
    };

    // Result layout: [5:0]=min1, [13:8]=min2, [16]=sign, [17]=ovf,
    // [31:24]=idx, [39:32]=cnt, everything else zero. A zero offset
    // reports the raw minima.
    function automatic logic [XLEN-1:0] cn_pack_result(cn_acc_t acc,
                                                      logic [CN_MAG_W-1:0] off);
        logic [XLEN-1:0] w_res;
        w_res        = '0;
        w_res[5:0]   = (acc.min1 > off) ? (acc.min1 - off) : '0;
        w_res[13:8]  = (acc.min2 > off) ? (acc.min2 - off) : '0;
        w_res[16]    = acc.sign;
        w_res[17]    = acc.ovf;
        w_res[31:24] = 8'(acc.idx);
        w_res[39:32] = 8'(acc.cnt);
        return w_res;
    endfunction

endpackage

// File: rtl/ldpc_cn_fu_if.sv
// ---------------------------------------------------------------------------
// ldpc_cn_fu_if
// Issue/writeback bus between ex_stage and the check-node unit.
//   fu_data_i   operator, operands and trans_id of the issued op
//   valid_i     fu_data_i valid for this unit
//   flush_i     kill in-flight result
//   ready_o     unit accepts an op this cycle
//   result_o    packed result (non-zero only for LDN_CN_RD)
//   valid_o     single-cycle completion pulse
//   trans_id_o  trans_id of the completing op
//   dbg_state_o accumulator occupancy state (observation only)
// Handshake: an op is taken on a cycle where valid_i & ready_o are both high;
// valid_i may rise without waiting for ready_o, and the issuer holds fu_data_i
// stable until it is taken. Each taken op completes exactly one cycle later.
// Modports: master = ex_stage issue side, slave = the functional unit.
// ---------------------------------------------------------------------------
interface ldpc_cn_fu_if
    import ldpc_cn_fu_pkg::*;
();
    fu_data_t                 fu_data_i;
    logic                     valid_i;
    logic                     flush_i;
    logic                     ready_o;
    logic [XLEN-1:0]          result_o;
    logic                     valid_o;
    logic [TRANS_ID_BITS-1:0] trans_id_o;
    cn_state_t                dbg_state_o;

    modport master (
        output fu_data_i, valid_i, flush_i,
        input  ready_o, result_o, valid_o, trans_id_o, dbg_state_o
    );

    modport slave (
        input  fu_data_i, valid_i, flush_i,
        output ready_o, result_o, valid_o, trans_id_o, dbg_state_o
    );
endinterface

// File: rtl/ldpc_cn_minfind.sv
// ---------------------------------------------------------------------------
// ldpc_cn_minfind
// Combinational saturating magnitude and min1/min2/index update for one LLR.
// Also used by the SIMD check-node variant in ex_stage.
// Ports:
//   i_llr   signed Q-bit LLR
//   i_min1  current smallest magnitude
//   i_min2  current second smallest magnitude
//   i_idx   position of current min1
//   i_cnt   position of this LLR in the row
//   o_mag   saturated magnitude of i_llr
//   o_min1/o_min2/o_idx  updated values
// ---------------------------------------------------------------------------
module ldpc_cn_minfind
    import ldpc_cn_fu_pkg::*;
(
    input  logic [Q-1:0]        i_llr,
    input  logic [CN_MAG_W-1:0] i_min1,
    input  logic [CN_MAG_W-1:0] i_min2,
    input  logic [CN_CNT_W-1:0] i_idx,
    input  logic [CN_CNT_W-1:0] i_cnt,
    output logic [CN_MAG_W-1:0] o_mag,
    output logic [CN_MAG_W-1:0] o_min1,
    output logic [CN_MAG_W-1:0] o_min2,
    output logic [CN_CNT_W-1:0] o_idx
);
    localparam logic [Q-1:0] LLR_MOST_NEG = {1'b1, {(Q-1){1'b0}}};
    localparam logic [Q-1:0] LLR_MAX_POS  = {1'b0, {(Q-1){1'b1}}};
    localparam logic [Q-1:0] MAG_MAX_Q    = Q'(CN_MAG_MAX);

    logic [Q-1:0] w_abs;

    always_comb begin
        // The most negative code has no positive twin; clamp it to +max.
        if (i_llr == LLR_MOST_NEG) begin
            w_abs = LLR_MAX_POS;
        end else if (i_llr[Q-1]) begin
            w_abs = ~i_llr + 1'b1;
        end else begin
            w_abs = i_llr;
        end

        if (w_abs > MAG_MAX_Q) begin
            o_mag = CN_MAG_MAX;
        end else begin
            o_mag = w_abs[CN_MAG_W-1:0];
        end

        // Strict compares: a tie with min1 only lands in min2, so idx keeps
        // the first occurrence of the minimum.
        o_min1 = i_min1;
        o_min2 = i_min2;
        o_idx  = i_idx;
        if (o_mag < i_min1) begin
            o_min2 = i_min1;
            o_min1 = o_mag;
            o_idx  = i_cnt;
        end else if (o_mag < i_min2) begin
            o_min2 = o_mag;
        end
    end

endmodule

// File: rtl/ldpc_cn_fu.sv
// ---------------------------------------------------------------------------
// ldpc_cn_fu
// Multi-cycle check-node functional unit. Streams one check-node row of
// signed LLRs (one per LDN_CN_ACC), tracking min1, min2, min1 index, sign
// parity, count and a sticky overflow flag. LDN_CN_RD returns the packed
// min-sum word; LDN_CN_CLR restarts the row.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous reset, active low
//   bus     ldpc_cn_fu_if.slave (fu_data_i, valid_i, flush_i, ready_o,
//           result_o, valid_o, trans_id_o, dbg_state_o)
// Optional feature: define LDPC_CN_OFFSET_EN to subtract operand_b[5:0]
// (offset-min-sum, floored at zero) from the reported minima on LDN_CN_RD.
// The stored accumulator is never modified by the offset.
// ---------------------------------------------------------------------------
module ldpc_cn_fu
    import ldpc_cn_fu_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    ldpc_cn_fu_if.slave  bus
);
    localparam logic [CN_CNT_W-1:0] CNT_FULL = CN_CNT_W'(DEG_MAX);

    cn_state_t                r_state;
    cn_state_t                w_state_nxt;
    cn_acc_t                  r_acc;
    cn_acc_t                  w_acc_nxt;
    logic                     r_valid;
    logic [XLEN-1:0]          r_result;
    logic [XLEN-1:0]          w_result_nxt;
    logic [TRANS_ID_BITS-1:0] r_tid;

    logic                     w_is_cn;
    logic                     w_accept;
    logic [CN_MAG_W-1:0]      w_off;
    logic [CN_CNT_W-1:0]      w_cnt_inc;
    logic [CN_MAG_W-1:0]      w_mag;
    logic [CN_MAG_W-1:0]      w_min1;
    logic [CN_MAG_W-1:0]      w_min2;
    logic [CN_CNT_W-1:0]      w_idx;
    logic                     w_unused;

    assign w_is_cn = (bus.fu_data_i.operation == LDN_CN_CLR) ||
                     (bus.fu_data_i.operation == LDN_CN_ACC) ||
                     (bus.fu_data_i.operation == LDN_CN_RD);

    // Held low in reset; a flush in the issue cycle refuses the op.
    assign bus.ready_o = rst_ni & ~bus.flush_i;
    // Ops for other units share the bus and are silently ignored.
    assign w_accept    = bus.valid_i & bus.ready_o & w_is_cn;

`ifdef LDPC_CN_OFFSET_EN
    assign w_off = bus.fu_data_i.operand_b[CN_MAG_W-1:0];
`else
    assign w_off = '0;
`endif

    assign w_unused = ^{bus.fu_data_i.operand_a[XLEN-1:Q], bus.fu_data_i.operand_b, w_mag};

    assign w_cnt_inc = r_acc.cnt + 1'b1;

    ldpc_cn_minfind u_minfind (
        .i_llr  (bus.fu_data_i.operand_a[Q-1:0]),
        .i_min1 (r_acc.min1),
        .i_min2 (r_acc.min2),
        .i_idx  (r_acc.idx),
        .i_cnt  (r_acc.cnt),
        .o_mag  (w_mag),
        .o_min1 (w_min1),
        .o_min2 (w_min2),
        .o_idx  (w_idx)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_result_nxt = '0;
        if (w_accept) begin
            case (bus.fu_data_i.operation)
                LDN_CN_CLR: begin
                    w_state_nxt = CN_EMPTY;
                    w_acc_nxt   = CN_ACC_RST;
                end
                LDN_CN_ACC: begin
                    if (r_state == CN_FULL) begin
                        // Row already holds DEG_MAX entries: drop the LLR
                        // but remember that software overran the row.
                        w_acc_nxt.ovf = 1'b1;
                    end else begin
                        w_acc_nxt.min1 = w_min1;
                        w_acc_nxt.min2 = w_min2;
                        w_acc_nxt.idx  = w_idx;
                        w_acc_nxt.sign = r_acc.sign ^ bus.fu_data_i.operand_a[Q-1];
                        w_acc_nxt.cnt  = w_cnt_inc;
                        w_state_nxt    = (w_cnt_inc == CNT_FULL) ? CN_FULL : CN_ACCUM;
                    end
                end
                LDN_CN_RD: begin
                    w_result_nxt = cn_pack_result(r_acc, w_off);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= CN_EMPTY;
            r_acc    <= CN_ACC_RST;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_tid    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_valid  <= w_accept;
            r_result <= w_result_nxt;
            if (w_accept) begin
                r_tid <= bus.fu_data_i.trans_id;
            end
        end
    end

    // A flush during the completion cycle kills the result; the accumulator
    // update already happened and is intentionally not rolled back.
    assign bus.valid_o     = r_valid & ~bus.flush_i;
    assign bus.result_o    = r_result;
    assign bus.trans_id_o  = r_tid;
    assign bus.dbg_state_o = r_state;

endmodule

// File: tb/tb_ldpc_cn_fu.sv
module tb_ldpc_cn_fu;
    import ldpc_cn_fu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ldpc_cn_fu_if u_if ();

    ldpc_cn_fu dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (u_if)
    );

    // ---------------- scoreboard state ----------------
    logic [XLEN-1:0]          exp_q[$];
    logic [TRANS_ID_BITS-1:0] exp_tid_q[$];
    int                       exp_cyc_q[$];
    int                       checks = 0;
    int                       errors = 0;
    logic [TRANS_ID_BITS-1:0] tid = '0;

    task automatic check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [XLEN-1:0] rd_word(int min1, int min2, int idx, int sgn,
                                                int ovf, int cnt);
        logic [XLEN-1:0] w;
        w        = '0;
        w[5:0]   = min1[5:0];
        w[13:8]  = min2[5:0];
        w[16]    = sgn[0];
        w[17]    = ovf[0];
        w[31:24] = idx[7:0];
        w[39:32] = cnt[7:0];
        return w;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && u_if.valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid_o=1 tid=%0d result=%0h, expected no completion (cycle %0d)",
                         u_if.trans_id_o, u_if.result_o, cyc);
            end else begin
                logic [XLEN-1:0]          e_res;
                logic [TRANS_ID_BITS-1:0] e_tid;
                int                       e_cyc;
                e_res = exp_q.pop_front();
                e_tid = exp_tid_q.pop_front();
                e_cyc = exp_cyc_q.pop_front();
                check("result", u_if.result_o, e_res);
                check("trans_id", XLEN'(u_if.trans_id_o), XLEN'(e_tid));
                check("latency_cycle", XLEN'(cyc), XLEN'(e_cyc));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the next one.
    task automatic issue(fu_op_t op, int a, logic [XLEN-1:0] b, logic flush,
                         logic expect_done, logic [XLEN-1:0] exp_res);
        u_if.fu_data_i.operation = op;
        u_if.fu_data_i.operand_a = {{(XLEN-8){a[7]}}, a[7:0]};
        u_if.fu_data_i.operand_b = b;
        u_if.fu_data_i.trans_id  = tid;
        u_if.valid_i             = 1'b1;
        u_if.flush_i             = flush;
        if (expect_done) begin
            exp_q.push_back(exp_res);
            exp_tid_q.push_back(tid);
            exp_cyc_q.push_back(cyc + 1);
        end
        tid++;
        @(posedge clk);
        #1;
        u_if.valid_i = 1'b0;
        u_if.flush_i = 1'b0;
    endtask

    task automatic clr();
        issue(LDN_CN_CLR, 0, '0, 1'b0, 1'b1, '0);
    endtask

    task automatic acc(int v);
        issue(LDN_CN_ACC, v, '0, 1'b0, 1'b1, '0);
    endtask

    task automatic rd(logic [XLEN-1:0] b, logic [XLEN-1:0] exp_res);
        issue(LDN_CN_RD, 0, b, 1'b0, 1'b1, exp_res);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n         = 1'b0;
        u_if.fu_data_i = '0;
        u_if.valid_i  = 1'b0;
        u_if.flush_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", XLEN'(u_if.ready_o), '0);
        check("rst_valid", XLEN'(u_if.valid_o), '0);
        check("rst_result", u_if.result_o, '0);
        check("rst_trans_id", XLEN'(u_if.trans_id_o), '0);
        check("rst_state", XLEN'(u_if.dbg_state_o), XLEN'(CN_EMPTY));
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        check("ready_after_rst", XLEN'(u_if.ready_o), 1);

        // RD straight out of reset
        rd('0, rd_word(63, 63, 0, 0, 0, 0));

        // basic row
        clr();
        acc(5); acc(-20); acc(3); acc(-7);
        rd('0, rd_word(3, 5, 2, 0, 0, 4));
        check("state_accum", XLEN'(u_if.dbg_state_o), XLEN'(CN_ACCUM));

        // saturation, two negatives
        clr();
        acc(-128); acc(-64); acc(90);
        rd('0, rd_word(63, 63, 0, 0, 0, 3));

        // tie keeps first index, single negative gives sign 1
        clr();
        acc(4); acc(4); acc(-40);
        rd('0, rd_word(4, 4, 0, 1, 0, 3));

        // overflow: DEG_MAX+1 ACCs
        clr();
        repeat (DEG_MAX + 1) acc(1);
        check("full_held", XLEN'(u_if.dbg_state_o), XLEN'(CN_FULL));
        rd('0, rd_word(1, 1, 0, 0, 1, 32));
        clr();
        check("state_empty_after_clr", XLEN'(u_if.dbg_state_o), XLEN'(CN_EMPTY));
        rd('0, rd_word(63, 63, 0, 0, 0, 0));

        // non-CN op is ignored
        issue(ADD, 5, '0, 1'b0, 1'b0, '0);
        rd('0, rd_word(63, 63, 0, 0, 0, 0));

        // flush in issue cycle: op refused, no completion
        clr();
        acc(10);
        idle();
        issue(LDN_CN_ACC, 2, '0, 1'b1, 1'b0, '0);
        rd('0, rd_word(10, 63, 0, 0, 0, 1));
        idle();
        // flush in completion cycle: no valid_o, but accumulator advanced
        issue(LDN_CN_ACC, 2, '0, 1'b0, 1'b0, '0);
        u_if.flush_i = 1'b1;
        #1;
        check("flush_kills_valid", XLEN'(u_if.valid_o), '0);
        idle();
        u_if.flush_i = 1'b0;
        rd('0, rd_word(2, 10, 1, 0, 0, 2));

`ifdef LDPC_CN_OFFSET_EN
        clr();
        acc(3); acc(10);
        rd(64'd4, rd_word(0, 6, 0, 0, 0, 2));
        rd(64'd0, rd_word(3, 10, 0, 0, 0, 2));
`endif

        // reset mid-row with an op in flight
        clr();
        acc(9);
        issue(LDN_CN_ACC, -1, '0, 1'b0, 1'b0, '0);
        rst_n = 1'b0;
        #1;
        check("midrow_rst_valid", XLEN'(u_if.valid_o), '0);
        check("midrow_rst_state", XLEN'(u_if.dbg_state_o), XLEN'(CN_EMPTY));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        rd('0, rd_word(63, 63, 0, 0, 0, 0));

        repeat (3) idle();
        check("scoreboard_drained", XLEN'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
